// File: rtl/centroid_div_sched.sv
// Shares one sequential divider between the X and Y centroid divisions and publishes a coherent (x,y) pair.
// Optional divider watchdog: define CENTROID_DIV_TIMEOUT_EN.
module centroid_div_sched #(
  parameter int M       = 30,
  parameter int PIX     = 20,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_end,
  input  logic [M-1:0]   m10_in,
  input  logic [M-1:0]   m01_in,
  input  logic [PIX-1:0] m00_in,
  output logic           div_start,
  output logic [DW-1:0]  div_dividend,
  output logic [PIX-1:0] div_divisor,
  input  logic [DW-1:0]  div_quotient,
  input  logic           div_qv,
  output logic [11:0]    x,
  output logic [11:0]    y,
  output logic           xy_valid,
  output logic           busy,
  output logic           empty,
  output logic           overrun,
  output logic           div_timeout
);

  typedef enum logic [2:0] {IDLE, START_X, WAIT_X, START_Y, WAIT_Y, DONE} state_t;

  state_t         state;
  logic [M-1:0]   m10_l;
  logic [M-1:0]   m01_l;
  logic [PIX-1:0] m00_l;
  logic [11:0]    x_tmp;
  logic           in_wait;
  logic           timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("centroid_div_sched: TIMEOUT must be at least 1");
  end

  function automatic logic [11:0] sat12(input logic [DW-1:0] q);
    if (|q[DW-1:12]) return 12'hFFF;
    return q[11:0];
  endfunction

  // Operands come straight from the latches, so they stay put for the whole division.
  assign div_start    = (state == START_X) || (state == START_Y);
  assign div_dividend = ((state == START_Y) || (state == WAIT_Y)) ? {{(DW-M){1'b0}}, m01_l}
                                                                  : {{(DW-M){1'b0}}, m10_l};
  assign div_divisor  = m00_l;
  assign busy         = (state != IDLE);
  assign in_wait      = (state == WAIT_X) || (state == WAIT_Y);
  assign overrun      = frame_end && (state != IDLE) && (state != DONE);
  assign div_timeout  = timeout_hit;

`ifdef CENTROID_DIV_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = in_wait && !div_qv && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Cleared in the start cycle so every WAIT state begins counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (div_start) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      m10_l    <= '0;
      m01_l    <= '0;
      m00_l    <= '0;
      x_tmp    <= '0;
      x        <= '0;
      y        <= '0;
      xy_valid <= 1'b0;
      empty    <= 1'b0;
    end else begin
      xy_valid <= 1'b0;
      empty    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (frame_end) begin
            m10_l <= m10_in;
            m01_l <= m01_in;
            m00_l <= m00_in;
            if (m00_in == '0) empty <= 1'b1;
            else              state <= START_X;
          end
        end
        START_X: state <= WAIT_X;
        WAIT_X: begin
          if (div_qv) begin
            x_tmp <= sat12(div_quotient);
            state <= START_Y;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        START_Y: state <= WAIT_Y;
        WAIT_Y: begin
          // x and y are written on the same edge so readers never see a mixed pair.
          if (div_qv) begin
            x        <= x_tmp;
            y        <= sat12(div_quotient);
            xy_valid <= 1'b1;
            state    <= DONE;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_div_sched.sv
// Scoreboard bench for centroid_div_sched with a 34-cycle behavioural divider.
// Covers the CENTROID_DIV_TIMEOUT_EN build as well when that macro is defined.
module tb_centroid_div_sched;

  localparam int M   = 30;
  localparam int PIX = 20;
  localparam int DW  = 32;
  localparam int DIV_LAT = 34;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_end = 1'b0;
  logic [M-1:0]   m10_in = '0;
  logic [M-1:0]   m01_in = '0;
  logic [PIX-1:0] m00_in = '0;
  logic           div_start;
  logic [DW-1:0]  div_dividend;
  logic [PIX-1:0] div_divisor;
  logic [DW-1:0]  div_quotient = '0;
  logic           div_qv = 1'b0;
  logic [11:0]    x;
  logic [11:0]    y;
  logic           xy_valid;
  logic           busy;
  logic           empty;
  logic           overrun;
  logic           div_timeout;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int n_start = 0, n_empty = 0, n_overrun = 0, n_xy = 0, n_timeout = 0;
  int last_start = 0, last_timeout = 0;
  logic div_en = 1'b1;
  int div_cnt = 0;
  logic [23:0] sb[$];

  centroid_div_sched dut (
    .clk(clk), .rst(rst), .frame_end(frame_end),
    .m10_in(m10_in), .m01_in(m01_in), .m00_in(m00_in),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .x(x), .y(y), .xy_valid(xy_valid), .busy(busy),
    .empty(empty), .overrun(overrun), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural divider: restarts on every start, answers DIV_LAT cycles later.
  always @(posedge clk) begin
    if (div_start) begin
      div_quotient <= div_dividend / {{(DW-PIX){1'b0}}, div_divisor};
      div_cnt      <= DIV_LAT;
      div_qv       <= 1'b0;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
      div_qv  <= (div_cnt == 1) && div_en;
    end else begin
      div_qv <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] refCoord(input int unsigned num, input int unsigned den);
    int unsigned q;
    q = num / den;
    return (q > 4095) ? 12'd4095 : q[11:0];
  endfunction

  // Monitor: counts pulses and pops the scoreboard on every published pair.
  always @(negedge clk) begin
    logic [23:0] e;
    cycle++;
    if (div_start) begin n_start++; last_start = cycle; end
    if (empty) n_empty++;
    if (overrun) n_overrun++;
    if (div_timeout) begin n_timeout++; last_timeout = cycle; end
    if (xy_valid) begin
      n_xy++;
      if (sb.size() == 0) begin
        checkOutput("xy_unexpected", 32'(xy_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("x", 32'(x), 32'(e[23:12]));
        checkOutput("y", 32'(y), 32'(e[11:0]));
      end
    end
  end

  task automatic applyStimulus(input int unsigned m10, input int unsigned m01, input int unsigned m00,
                               input bit expect_pair);
    @(posedge clk); #2;
    m10_in = M'(m10);
    m01_in = M'(m01);
    m00_in = PIX'(m00);
    frame_end = 1'b1;
    if (expect_pair) sb.push_back({refCoord(m10, m00), refCoord(m01, m00)});
    @(posedge clk); #2;
    frame_end = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) checkOutput("idle_wait_expired", 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, xy0, e0, o0, n;

    #3;
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_div_start", 32'(div_start), 32'd0);
    checkOutput("rst_dividend", div_dividend, 32'd0);
    checkOutput("rst_xy_valid", 32'(xy_valid), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and start latency
    s0 = n_start; xy0 = n_xy;
    applyStimulus(3200, 6400, 100, 1'b1);
    @(negedge clk);
    checkOutput("start_latency", 32'(div_start), 32'd1);
    checkOutput("dividend_x", div_dividend, 32'd3200);
    checkOutput("divisor", 32'(div_divisor), 32'd100);
    waitIdle(200);
    checkOutput("starts_basic", 32'(n_start - s0), 32'd2);
    checkOutput("xy_count_basic", 32'(n_xy - xy0), 32'd1);
    checkOutput("busy_after", 32'(busy), 32'd0);

    // Empty frame
    s0 = n_start; xy0 = n_xy; e0 = n_empty;
    applyStimulus(55, 77, 0, 1'b0);
    @(negedge clk);
    checkOutput("empty_pulse", 32'(empty), 32'd1);
    checkOutput("empty_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("empty_count", 32'(n_empty - e0), 32'd1);
    checkOutput("empty_no_start", 32'(n_start - s0), 32'd0);
    checkOutput("empty_x_hold", 32'(x), 32'd32);
    checkOutput("empty_y_hold", 32'(y), 32'd64);
    checkOutput("empty_no_xy", 32'(n_xy - xy0), 32'd0);

    // Overrun while the X division is in flight
    xy0 = n_xy; o0 = n_overrun; s0 = n_start;
    applyStimulus(3200, 6400, 100, 1'b1);
    repeat (5) @(negedge clk);
    applyStimulus(1000, 1000, 10, 1'b0);
    waitIdle(200);
    checkOutput("overrun_count", 32'(n_overrun - o0), 32'd1);
    checkOutput("overrun_xy_count", 32'(n_xy - xy0), 32'd1);
    checkOutput("overrun_starts", 32'(n_start - s0), 32'd2);

    // Saturation and a small quotient
    applyStimulus(5000, 7, 1, 1'b1);
    waitIdle(200);
    applyStimulus(7, 7, 2, 1'b1);
    waitIdle(200);
    checkOutput("sat_x_final", 32'(x), 32'd3);

    // Reset during WAIT_Y aborts, next frame still works
    s0 = n_start; xy0 = n_xy;
    applyStimulus(3200, 6400, 100, 1'b0);
    n = 0;
    while (n_start - s0 < 2 && n < 200) begin @(negedge clk); n++; end
    checkOutput("reach_wait_y", 32'(n_start - s0), 32'd2);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_x", 32'(x), 32'd0);
    checkOutput("abort_y", 32'(y), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;
    checkOutput("abort_no_xy", 32'(n_xy - xy0), 32'd0);
    applyStimulus(200, 200, 10, 1'b1);
    waitIdle(200);
    checkOutput("post_reset_x", 32'(x), 32'd20);

    // Divider never answers
    div_en = 1'b0;
    xy0 = n_xy;
`ifdef CENTROID_DIV_TIMEOUT_EN
    o0 = n_timeout;
    applyStimulus(300, 300, 10, 1'b0);
    n = 0;
    while (n_timeout == o0 && n < 300) begin @(negedge clk); n++; end
    checkOutput("timeout_seen", 32'(n_timeout - o0), 32'd1);
    checkOutput("timeout_delay", 32'(last_timeout - last_start), 32'd64);
    @(negedge clk);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_x_hold", 32'(x), 32'd20);
    checkOutput("timeout_no_xy", 32'(n_xy - xy0), 32'd0);
`else
    applyStimulus(300, 300, 10, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("hang_busy", 32'(busy), 32'd1);
    checkOutput("hang_no_xy", 32'(n_xy - xy0), 32'd0);
    checkOutput("hang_no_timeout", 32'(n_timeout), 32'd0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
`endif
    div_en = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
